// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable clock dividers sharing one divisor write port.
// Optional CLK_DIV_SYNC_EN adds a sync input that realigns every channel at once.
module clk_div_bank #(
  parameter  int unsigned NCH         = 4,
  parameter  int unsigned CW          = 32,
  parameter  int unsigned DEFAULT_DIV = 100000,
  localparam int unsigned WCH         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic           sync,
`endif
  input  logic [NCH-1:0] en,
  input  logic           wr_en,
  input  logic [WCH-1:0] wr_ch,
  input  logic [CW-1:0]  wr_div,
  input  logic           wr_oneshot,
  output logic           wr_ack,
  output logic           wr_err,
  output logic [NCH-1:0] tick,
  output logic [NCH-1:0] sq,
  output logic [NCH-1:0] done
);

  localparam logic [WCH:0] NCH_W = (WCH+1)'(NCH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [CW-1:0]  cnt_q  [NCH];
  logic [CW-1:0]  cnt_d  [NCH];
  logic [CW-1:0]  div_q  [NCH];
  logic [CW-1:0]  div_d  [NCH];
  logic [CW-1:0]  pdiv_q [NCH];
  logic [CW-1:0]  pdiv_d [NCH];
  state_e         st_q   [NCH];
  state_e         st_d   [NCH];
  logic [NCH-1:0] pmode_q, pmode_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] sq_q, sq_d;
  logic [NCH-1:0] done_q, done_d;
  logic           wr_ack_q, wr_err_q;
  logic           wr_ok, wr_bad, sync_w;
  logic [NCH-1:0] hit;

`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  assign wr_ok  = wr_en && ({1'b0, wr_ch} < NCH_W);
  assign wr_bad = wr_en && !({1'b0, wr_ch} < NCH_W);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NCH; i++) begin
      hit[i] = wr_ok && (wr_ch == WCH'(i));
    end
  end

  // Per-channel next state: sync, then immediate write (idle channel), then counting.
  always_comb begin
    pmode_d = pmode_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    tick_d  = '0;
    sq_d    = sq_q;
    done_d  = done_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = div_q[i];
      pdiv_d[i] = pdiv_q[i];
      st_d[i]   = st_q[i];
      if (sync_w) begin
        cnt_d[i]  = '0;
        sq_d[i]   = 1'b0;
        done_d[i] = 1'b0;
        pend_d[i] = 1'b0;
        st_d[i]   = en[i] ? ST_RUN : ST_HOLD;
        if (pend_q[i]) begin
          div_d[i]  = pdiv_q[i];
          mode_d[i] = pmode_q[i];
        end
        if (hit[i]) begin
          div_d[i]  = wr_div;
          mode_d[i] = wr_oneshot;
        end
      end else if (hit[i] && (st_q[i] != ST_RUN || !en[i])) begin
        div_d[i]  = wr_div;
        mode_d[i] = wr_oneshot;
        cnt_d[i]  = '0;
        done_d[i] = 1'b0;
        pend_d[i] = 1'b0;
        st_d[i]   = en[i] ? ST_RUN : ST_HOLD;
      end else begin
        if (st_q[i] == ST_DONE) begin
          cnt_d[i] = '0;
        end else if (!en[i]) begin
          st_d[i] = ST_HOLD;
        end else begin
          st_d[i] = ST_RUN;
          if (cnt_q[i] == div_q[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
            sq_d[i]   = ~sq_q[i];
            if (pend_q[i]) begin
              div_d[i]  = pdiv_q[i];
              mode_d[i] = pmode_q[i];
              pend_d[i] = 1'b0;
            end
            if (mode_q[i]) begin
              done_d[i] = 1'b1;
              st_d[i]   = ST_DONE;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end
        // A write landing on a terminal count is staged for the following one.
        if (hit[i]) begin
          pdiv_d[i]  = wr_div;
          pmode_d[i] = wr_oneshot;
          pend_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= CW'(DEFAULT_DIV);
        pdiv_q[i] <= '0;
        st_q[i]   <= ST_RUN;
      end
      pmode_q  <= '0;
      pend_q   <= '0;
      mode_q   <= '0;
      tick_q   <= '0;
      sq_q     <= '0;
      done_q   <= '0;
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]  <= cnt_d[i];
        div_q[i]  <= div_d[i];
        pdiv_q[i] <= pdiv_d[i];
        st_q[i]   <= st_d[i];
      end
      pmode_q  <= pmode_d;
      pend_q   <= pend_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      sq_q     <= sq_d;
      done_q   <= done_d;
      wr_ack_q <= wr_ok;
      wr_err_q <= wr_bad;
    end
  end

  assign tick   = tick_q;
  assign sq     = sq_q;
  assign done   = done_q;
  assign wr_ack = wr_ack_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: expectations are queued per cycle when stimulus is driven.
module tb_clk_div_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  en;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_div;
  logic        wr_oneshot;
  logic        wr_ack, wr_err;
  logic [3:0]  tick, sq, done;
`ifdef CLK_DIV_SYNC_EN
  logic        sync;
`endif

  logic        e_wr_en;
  logic [1:0]  e_wr_ch;
  logic        e_ack, e_err;
  logic [2:0]  e_tick, e_sq, e_done;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int R, R2, S;

  typedef struct packed {
    int          cyc;
    logic [2:0]  kind;
    logic [3:0]  mask;
    logic [3:0]  exp;
    logic [47:0] tag;
  } exp_t;
  exp_t sbq[$];
  logic [3:0] o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clk_div_bank #(.NCH(4), .CW(16), .DEFAULT_DIV(3)) u_dut (
    .clk(clk), .rst(rst),
`ifdef CLK_DIV_SYNC_EN
    .sync(sync),
`endif
    .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div), .wr_oneshot(wr_oneshot),
    .wr_ack(wr_ack), .wr_err(wr_err), .tick(tick), .sq(sq), .done(done)
  );

  // A 2-bit wr_ch cannot encode channel 5, so the out-of-range write uses a 3-channel bank.
  clk_div_bank #(.NCH(3), .CW(16), .DEFAULT_DIV(3)) u_err (
    .clk(clk), .rst(rst),
`ifdef CLK_DIV_SYNC_EN
    .sync(1'b0),
`endif
    .en(3'b111), .wr_en(e_wr_en), .wr_ch(e_wr_ch), .wr_div(16'd7), .wr_oneshot(1'b0),
    .wr_ack(e_ack), .wr_err(e_err), .tick(e_tick), .sq(e_sq), .done(e_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic push(input logic [47:0] tag, input int c, input logic [2:0] kind,
                      input logic [3:0] mask, input logic [3:0] exp);
    exp_t e;
    e.cyc = c; e.kind = kind; e.mask = mask; e.exp = exp; e.tag = tag;
    sbq.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d, input logic m);
    wr_en = 1'b1; wr_ch = ch; wr_div = d; wr_oneshot = m;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Compare every expectation due in this cycle against the live outputs.
  always @(negedge clk) begin
    for (int k = sbq.size() - 1; k >= 0; k--) begin
      if (sbq[k].cyc == cyc) begin
        case (sbq[k].kind)
          3'd0:    o = tick;
          3'd1:    o = sq;
          3'd2:    o = done;
          3'd3:    o = {2'b00, wr_err, wr_ack};
          3'd4:    o = {1'b0, e_tick};
          3'd5:    o = {2'b00, e_err, e_ack};
          default: o = {1'b0, e_sq};
        endcase
        check($sformatf("%s", sbq[k].tag), 32'(o & sbq[k].mask), 32'(sbq[k].exp & sbq[k].mask));
        sbq.delete(k);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 4'hF; wr_en = 1'b0; wr_ch = '0; wr_div = '0; wr_oneshot = 1'b0;
    e_wr_en = 1'b0; e_wr_ch = '0;
`ifdef CLK_DIV_SYNC_EN
    sync = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rs_tick", 32'(tick), 32'h0);
    check("rs_sq", 32'(sq), 32'h0);
    check("rs_done", 32'(done), 32'h0);
    check("rs_ack", 32'({wr_err, wr_ack}), 32'h0);

    // Default divisor 3: tick every 4 cycles, sq period 8, first tick 4 edges after release.
    R = cyc;
    for (int c = 1; c <= 12; c++) begin
      push("t1_tik", R + c, 3'd0, 4'hF, (c % 4 == 0) ? 4'hF : 4'h0);
      push("t1_sq ", R + c, 3'd1, 4'hF, ((c / 4) % 2 == 1) ? 4'hF : 4'h0);
    end
    rst = 1'b1;

    // Retimed write: old period on ch1 completes at R+16, then period 10.
    wait_cyc(R + 13);
    push("t2_ack", R + 14, 3'd3, 4'h3, 4'b0001);
    push("t2_ack", R + 15, 3'd3, 4'h3, 4'b0000);
    for (int c = 14; c <= 37; c++)
      push("t2_tik", R + c, 3'd0, 4'b0010, (c == 16 || c == 26 || c == 36) ? 4'b0010 : 4'h0);
    wr(2'd1, 16'd9, 1'b0);

    // Write coinciding with ch0 terminal count applies one terminal later.
    wait_cyc(R + 39);
    for (int c = 40; c <= 49; c++)
      push("t3_tik", R + c, 3'd0, 4'b0001,
           (c == 40 || c == 44 || c == 46 || c == 48) ? 4'b0001 : 4'h0);
    wr(2'd0, 16'd1, 1'b0);

    // One-shot on held ch2: single tick 6 cycles after enable, then done.
    wait_cyc(R + 50);
    en[2] = 1'b0;
    for (int c = 51; c <= 80; c++) begin
      push("t4_tik", R + c, 3'd0, 4'b0100, (c == 60) ? 4'b0100 : 4'h0);
      push("t4_don", R + c, 3'd2, 4'hF, (c >= 60) ? 4'b0100 : 4'h0);
    end
    wait_cyc(R + 52);
    push("t4_ack", R + 53, 3'd3, 4'h3, 4'b0001);
    wr(2'd2, 16'd5, 1'b1);
    wait_cyc(R + 54);
    en[2] = 1'b1;

    // div=0 on ch3: constant tick, sq toggling every cycle, then frozen by en=0.
    wait_cyc(R + 80);
    push("t5_ack", R + 81, 3'd3, 4'h3, 4'b0001);
    for (int c = 82; c <= 95; c++) begin
      push("t5_tik", R + c, 3'd0, 4'b1000, (c >= 84 && c <= 90) ? 4'b1000 : 4'h0);
      if (c < 84)       push("t5_sq ", R + c, 3'd1, 4'b1000, 4'h0);
      else if (c <= 90) push("t5_sq ", R + c, 3'd1, 4'b1000, ((21 + c - 84) % 2 == 1) ? 4'b1000 : 4'h0);
      else              push("t5_sq ", R + c, 3'd1, 4'b1000, 4'b1000);
    end
    wr(2'd3, 16'd0, 1'b0);
    wait_cyc(R + 90);
    en[3] = 1'b0;

    // Out-of-range channel: error pulse, no ack, counting undisturbed.
    wait_cyc(R + 100);
    push("t6_err", R + 101, 3'd5, 4'h3, 4'b0010);
    push("t6_err", R + 102, 3'd5, 4'h3, 4'b0000);
    for (int c = 101; c <= 108; c++) begin
      push("t6_tik", R + c, 3'd4, 4'h7, (c % 4 == 0) ? 4'h7 : 4'h0);
      push("t6_sq ", R + c, 3'd6, 4'h7, ((c / 4) % 2 == 1) ? 4'h7 : 4'h0);
    end
    e_wr_en = 1'b1; e_wr_ch = 2'd3;
    @(negedge clk);
    e_wr_en = 1'b0;

    // Asynchronous reset with a write pending on ch0.
    wait_cyc(R + 110);
    check("pre_don", 32'(done), 32'h4);
    wr(2'd0, 16'd7, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("ar_ack", 32'({wr_err, wr_ack}), 32'h0);
    check("ar_tik", 32'(tick), 32'h0);
    check("ar_sq", 32'(sq), 32'h0);
    check("ar_don", 32'(done), 32'h0);
    en = 4'hF;
    wait_cyc(R + 114);
    R2 = cyc;
    for (int c = 1; c <= 12; c++) begin
      push("r2_tik", R2 + c, 3'd0, 4'hF, (c % 4 == 0) ? 4'hF : 4'h0);
      push("r2_sq ", R2 + c, 3'd1, 4'hF, ((c / 4) % 2 == 1) ? 4'hF : 4'h0);
    end
    rst = 1'b1;

`ifdef CLK_DIV_SYNC_EN
    // Skew ch2 by two cycles, then sync realigns every channel.
    wait_cyc(R2 + 13);
    en[2] = 1'b0;
    wait_cyc(R2 + 15);
    en[2] = 1'b1;
    wait_cyc(R2 + 20);
    S = cyc;
    for (int c = 1; c <= 10; c++) begin
      push("sy_tik", S + c, 3'd0, 4'hF, (c == 5 || c == 9) ? 4'hF : 4'h0);
      push("sy_sq ", S + c, 3'd1, 4'hF, (((c - 1) / 4) % 2 == 1) ? 4'hF : 4'h0);
      push("sy_don", S + c, 3'd2, 4'hF, 4'h0);
    end
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    wait_cyc(S + 12);
`else
    wait_cyc(R2 + 14);
`endif

    check("sb_emp", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
